// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_pkg : shared AES-128 constants, S-box tables, GF(2^8) helpers and the  |
// |           combinational round-key expansion gen_key.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes_pkg;

    localparam int c_ROUNDS = 10;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
    typedef logic [10:0][127:0] rkeys_t;

    // Entry 0 sits in the top byte so row-by-row reading matches the FIPS-197 tables.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16};

    localparam logic [2047:0] c_INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e, 128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692, 128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506, 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673, 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b, 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f, 128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961, 128'h172b047e_ba77d626_e1691463_55210c7d};

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return c_INV_SBOX[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic rkeys_t gen_key(input logic [127:0] k);
        rkeys_t     rk;
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rk    = '0;
        rk[0] = k;
        {w0, w1, w2, w3} = k;
        rc = 8'h01;
        for (int r = 1; r <= c_ROUNDS; r++) begin
            t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rk[r] = {w0, w1, w2, w3};
            rc = xtime(rc);
        end
        return rk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inv_round : one combinational AES inverse round (InvShiftRows, InvSubBytes,|
// |             AddRoundKey, then InvMixColumns unless last is set).           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inv_round
    import aes_pkg::*;
(
    input  logic [127:0] ctx,
    input  logic [127:0] rkey,
    input  logic         last,
    output logic [127:0] ret
);

    logic [7:0] w_ark [16];
    logic [7:0] w_mix [16];

    // Byte i is row i%4 of column i/4; row r rotates right by r columns.
    always_comb begin
        w_ark = '{default: 8'h00};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_ark[4*c+r] = inv_sbox(ctx[127 - 8*(4*((c - r + 4) % 4) + r) -: 8])
                             ^ rkey[127 - 8*(4*c + r) -: 8];
            end
        end
    end

    always_comb begin
        w_mix = '{default: 8'h00};
        for (int c = 0; c < 4; c++) begin
            w_mix[4*c]   = gmul(w_ark[4*c], 8'h0e) ^ gmul(w_ark[4*c+1], 8'h0b)
                         ^ gmul(w_ark[4*c+2], 8'h0d) ^ gmul(w_ark[4*c+3], 8'h09);
            w_mix[4*c+1] = gmul(w_ark[4*c], 8'h09) ^ gmul(w_ark[4*c+1], 8'h0e)
                         ^ gmul(w_ark[4*c+2], 8'h0b) ^ gmul(w_ark[4*c+3], 8'h0d);
            w_mix[4*c+2] = gmul(w_ark[4*c], 8'h0d) ^ gmul(w_ark[4*c+1], 8'h09)
                         ^ gmul(w_ark[4*c+2], 8'h0e) ^ gmul(w_ark[4*c+3], 8'h0b);
            w_mix[4*c+3] = gmul(w_ark[4*c], 8'h0b) ^ gmul(w_ark[4*c+1], 8'h0d)
                         ^ gmul(w_ark[4*c+2], 8'h09) ^ gmul(w_ark[4*c+3], 8'h0e);
        end
    end

    always_comb begin
        ret = '0;
        for (int i = 0; i < 16; i++) begin
            ret[127 - 8*i -: 8] = last ? w_ark[i] : w_mix[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/top_aes_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | top_aes_dec : iterative AES-128 decryptor, one inverse round per clock.    |
// |   Option AES_DEC_KEY_LATCH_EN: capture key at start so it may change later.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module top_aes_dec
    import aes_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] din,
    input  logic [127:0] key,
    output logic [127:0] ptxt,
    output logic         busy,
    output logic         done
);

    state_t       r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_blk;
    logic [127:0] w_key;
    rkeys_t       w_rk;
    logic [127:0] w_rkey;
    logic         w_last;
    logic [127:0] w_ret;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [127:0] r_key;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key <= '0;
        end else if (r_state == IDLE && start) begin
            r_key <= key;
        end
    end

    // The E0 load still needs rk[10] of the live key; the copy only exists afterwards.
    assign w_key = (r_state == IDLE) ? key : r_key;
`else
    assign w_key = key;
`endif

    assign w_rk   = gen_key(w_key);
    assign w_rkey = w_rk[r_rnd];
    assign w_last = (r_rnd == 4'd0);

    inv_round u_inv_round (
        .ctx  (r_blk),
        .rkey (w_rkey),
        .last (w_last),
        .ret  (w_ret)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rnd   <= 4'd0;
            r_blk   <= '0;
            ptxt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_blk   <= din ^ w_rk[ROUNDS];
                        r_rnd   <= 4'(ROUNDS - 1);
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        ptxt    <= w_ret;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_blk <= w_ret;
                        r_rnd <= r_rnd - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/top_aes_dec.md
TOP_AES_DEC -- requirements
Module: top_aes_dec

Interface
REQ-001 SHALL have parameter ROUNDS, default 10, meaning number of AES rounds; only 10 (AES-128) is legal.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin decryption of din under key.
REQ-005 SHALL have port din  input  128  ciphertext block, byte 0 in bits [127:120].
REQ-006 SHALL have port key  input  128  AES-128 cipher key, same byte order as din.
REQ-007 SHALL have port ptxt  output  128  registered plaintext result.
REQ-008 SHALL have port busy  output  1  high while a decryption is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking ptxt valid.

Function
REQ-010 SHALL be an FSM with states IDLE and RUN, plus a 4-bit round counter rnd.
REQ-011 In IDLE with start=1 at edge E0: state SHALL load din ^ rk[10], rnd SHALL be set to 9, FSM SHALL go to RUN.
REQ-012 In RUN with rnd 9..1, each edge SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk[rnd]) and InvMixColumns, then decrement rnd.
REQ-013 In RUN with rnd=0, the edge SHALL apply InvShiftRows, InvSubBytes and AddRoundKey(rk[0]) without InvMixColumns, load ptxt, set done=1, and return to IDLE.
REQ-014 Latency SHALL be exactly 10 cycles: start sampled at E0, done high from E10 to E11.
REQ-015 done SHALL be high for exactly one cycle per accepted start.
REQ-016 busy SHALL be 1 from E0 to E10 and 0 otherwise, including the done cycle.
REQ-017 start while busy=1 SHALL be ignored, with no effect on state, rnd or outputs.
REQ-018 start asserted during the done cycle SHALL be accepted, since the FSM is in IDLE; back-to-back blocks therefore run every 11 cycles.
REQ-019 ptxt SHALL hold its value until the next done and SHALL NOT change during a subsequent RUN.
REQ-020 Round keys rk[0..10] SHALL come from the existing combinational gen_key expansion of key.
REQ-021 All GF(2^8) arithmetic SHALL use polynomial 0x11B; InvMixColumns coefficients SHALL be 0e,0b,0d,09.

Reset
REQ-022 reset=0 SHALL immediately force state IDLE, rnd=0, busy=0, done=0, ptxt=0 and the internal state register to 0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation, with no done pulse afterwards.
REQ-024 After reset deassertion, the first accepted start SHALL behave per REQ-011.

Configuration
REQ-025 When macro AES_DEC_KEY_LATCH_EN is defined, key SHALL be registered at E0 and expansion SHALL use the registered copy, so key may change during RUN.
REQ-026 When AES_DEC_KEY_LATCH_EN is undefined, expansion SHALL use key directly, and key SHALL be held stable from E0 through E10; results are undefined otherwise.

Structure
REQ-027 The shared package aes_pkg SHALL hold the inverse S-box table, the state-type enum (IDLE/RUN), the ROUNDS constant and the GF multiply functions xtime/gmul.
REQ-028 A single sub-module inv_round (inputs ctx, rkey, last; output ret) SHALL implement one combinational inverse round, instantiated once.

Verification
REQ-029 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, din 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done at E10, ptxt 00112233445566778899aabbccddeeff.
REQ-030 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, din 3925841d02dc09fbdc118597196a0b32 -> ptxt 3243f6a8885a308d313198a2e0370734.
REQ-031 Start re-pulsed at E3 and E7 of a running block -> ignored, single done at E10, ptxt correct.
REQ-032 Start asserted in the done cycle with the App. B vector after the C.1 vector -> second done exactly 11 cycles after the first, both results correct.
REQ-033 reset driven low at E5 of a run -> busy, done and ptxt go to 0 immediately, and no done follows.
REQ-034 With AES_DEC_KEY_LATCH_EN defined, key changed to all-ones at E2 of the C.1 vector -> ptxt still 00112233445566778899aabbccddeeff.
